// File: rtl/pfpu32_pkg.sv
// Shared pfpu32 types and constants.
//   - pfpu32_f2i_res_t : packed unit result (36 bits, zero-padded to the payload width by users)
//   - PFPU32_ID_*      : unit indices on the rounding arbiter request vector
package pfpu32_pkg;

  localparam int unsigned PFPU32_ID_W      = 3;
  localparam int unsigned PFPU32_F2I_RES_W = 36;

  localparam logic [PFPU32_ID_W-1:0] PFPU32_ID_ADDSUB = 3'd0;
  localparam logic [PFPU32_ID_W-1:0] PFPU32_ID_MUL    = 3'd1;
  localparam logic [PFPU32_ID_W-1:0] PFPU32_ID_I2F    = 3'd2;
  localparam logic [PFPU32_ID_W-1:0] PFPU32_ID_F2I    = 3'd3;

  typedef struct packed {
    logic        sign;
    logic [23:0] int24;
    logic [4:0]  shr5;
    logic [3:0]  shl4;
    logic        ovf;
    logic        snan;
  } pfpu32_f2i_res_t;

endpackage

// File: rtl/pfpu32_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
// Ports:
//   req    : request vector
//   ptr    : index holding highest priority (0..N-1)
//   gnt_c  : one-hot grant
//   idx_c  : index of the granted request
//   any_c  : at least one request present
module pfpu32_rr_pick
  import pfpu32_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]             req,
  input  logic [PFPU32_ID_W-1:0]   ptr,
  output logic [N-1:0]             gnt_c,
  output logic [PFPU32_ID_W-1:0]   idx_c,
  output logic                     any_c
);

  // Two descending passes, later writes win: indices below ptr (wrapped region)
  // first, then indices at/above ptr, so the lowest index >= ptr has top priority.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j] && (j < int'(ptr))) begin
        gnt_c    = '0;
        gnt_c[j] = 1'b1;
        idx_c    = PFPU32_ID_W'(j);
        any_c    = 1'b1;
      end
    end
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        gnt_c    = '0;
        gnt_c[j] = 1'b1;
        idx_c    = PFPU32_ID_W'(j);
        any_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pfpu32_rnd_arb.sv
// Arbitrates one-cycle result pulses from the pfpu32 units onto the shared
// rounding stage and generates the global pipeline advance.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : pipe flush, clears slots, output valid and pointer
//   req_rdy_i     : per-unit result pulse
//   req_data_i    : per-unit payload, unit i at [i*PAYLOAD_W +: PAYLOAD_W]
//   rnd_ready_i   : rounding stage accepts the output register
//   adv_o         : advance to unit pipelines (no backlog)
//   out_vld_o/out_id_o/out_data_o : output register
//   busy_o        : any slot or output register occupied
// Build option: PFPU32_RND_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of round-robin.
module pfpu32_rnd_arb
  import pfpu32_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PAYLOAD_W = 40
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_rdy_i,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data_i,
  input  logic                           rnd_ready_i,
  output logic                           adv_o,
  output logic                           out_vld_o,
  output logic [PFPU32_ID_W-1:0]         out_id_o,
  output logic [PAYLOAD_W-1:0]           out_data_o,
  output logic                           busy_o
);

  logic [NUM_REQ-1:0]      slot_vld;
  logic [PAYLOAD_W-1:0]    slot_data [NUM_REQ];
  logic [NUM_REQ-1:0]      gnt;
  logic [PFPU32_ID_W-1:0]  gnt_idx;
  logic                    gnt_any;
  logic [PFPU32_ID_W-1:0]  pick_ptr;
  logic [PAYLOAD_W-1:0]    win_data;
  logic                    load_en;
  logic                    gnt_fire;

  assign adv_o    = ~rst & ~(|slot_vld);
  assign load_en  = ~out_vld_o | rnd_ready_i;
  assign gnt_fire = load_en & gnt_any;
  assign busy_o   = (|slot_vld) | out_vld_o;

`ifdef PFPU32_RND_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PFPU32_ID_W-1:0] rr_ptr;

  // Round-robin pointer: one past the last winner, wrapping at NUM_REQ.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rr_ptr <= '0;
    end else if (gnt_fire) begin
      rr_ptr <= (gnt_idx == PFPU32_ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PFPU32_ID_W'(1);
    end
  end

  assign pick_ptr = rr_ptr;
`endif

  pfpu32_rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (slot_vld),
    .ptr   (pick_ptr),
    .gnt_c (gnt),
    .idx_c (gnt_idx),
    .any_c (gnt_any)
  );

  // Winner payload mux driven by the one-hot grant.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) win_data = slot_data[i];
    end
  end

  // Holding slots: capture only while advancing (all slots empty), so a
  // capture and a grant never target the same slot in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      slot_vld <= '0;
      if (rst) begin
        for (int i = 0; i < int'(NUM_REQ); i++) slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (adv_o && req_rdy_i[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_data[i] <= req_data_i[i*PAYLOAD_W +: PAYLOAD_W];
        end else if (gnt_fire && gnt[i]) begin
          slot_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // Output register: refills from the winner whenever it is free or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_o  <= 1'b0;
      out_id_o   <= '0;
      out_data_o <= '0;
    end else if (flush_i) begin
      out_vld_o  <= 1'b0;
    end else if (load_en) begin
      out_vld_o <= gnt_any;
      if (gnt_any) begin
        out_id_o   <= gnt_idx;
        out_data_o <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_pfpu32_rnd_arb.sv
// Directed self-checking bench for pfpu32_rnd_arb (default round-robin build).
module tb_pfpu32_rnd_arb;
  import pfpu32_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 40;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush_i = 1'b0;
  logic [N-1:0]           req_rdy_i = '0;
  logic [N*PW-1:0]        req_data_i = '0;
  logic                   rnd_ready_i = 1'b1;
  logic                   adv_o;
  logic                   out_vld_o;
  logic [PFPU32_ID_W-1:0] out_id_o;
  logic [PW-1:0]          out_data_o;
  logic                   busy_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  pfpu32_rnd_arb #(.NUM_REQ(N), .PAYLOAD_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .req_rdy_i   (req_rdy_i),
    .req_data_i  (req_data_i),
    .rnd_ready_i (rnd_ready_i),
    .adv_o       (adv_o),
    .out_vld_o   (out_vld_o),
    .out_id_o    (out_id_o),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] pat(input logic [PW-1:0] base, input int i);
    return base | PW'(i);
  endfunction

  task automatic load_pattern(input logic [PW-1:0] base);
    for (int i = 0; i < int'(N); i++) req_data_i[i*PW +: PW] = pat(base, i);
  endtask

  // Drive a one-cycle pulse; leaves time just after the capture edge.
  task automatic pulse(input logic [N-1:0] mask);
    check("adv_before_pulse", 64'(adv_o), 64'd1);
    req_rdy_i = mask;
    step();
    req_rdy_i = '0;
  endtask

  task automatic expect_out(input string tag, input int id, input logic [PW-1:0] data);
    check({tag, "_vld"},  64'(out_vld_o), 64'd1);
    check({tag, "_id"},   64'(out_id_o),  64'(id));
    check({tag, "_data"}, 64'(out_data_o), 64'(data));
  endtask

  initial begin
    // Reset
    step();
    step();
    check("rst_adv", 64'(adv_o), 64'd0);
    check("rst_vld", 64'(out_vld_o), 64'd0);
    check("rst_id", 64'(out_id_o), 64'd0);
    check("rst_data", 64'(out_data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_adv", 64'(adv_o), 64'd1);

    // Single pulse from the f2i unit
    req_data_i[int'(PFPU32_ID_F2I)*PW +: PW] = 40'h12_3456_789A;
    pulse(4'b1000);
    check("single_adv_low", 64'(adv_o), 64'd0);
    check("single_vld_early", 64'(out_vld_o), 64'd0);
    check("single_busy", 64'(busy_o), 64'd1);
    step();
    expect_out("single", 3, 40'h12_3456_789A);
    check("single_adv_back", 64'(adv_o), 64'd1);
    step();
    check("single_vld_idle", 64'(out_vld_o), 64'd0);
    check("single_busy_idle", 64'(busy_o), 64'd0);

    // All four together from pointer 0
    load_pattern(40'hA0_0000_0000);
    pulse(4'b1111);
    check("all_adv_0", 64'(adv_o), 64'd0);
    for (int g = 0; g < 4; g++) begin
      step();
      expect_out("all_grant", g, pat(40'hA0_0000_0000, g));
      check("all_adv", 64'(adv_o), (g == 3) ? 64'd1 : 64'd0);
    end
    step();
    check("all_idle", 64'(out_vld_o), 64'd0);

    // Back-pressure with ids 1 and 2
    load_pattern(40'hB0_0000_0000);
    rnd_ready_i = 1'b0;
    pulse(4'b0110);
    step();
    expect_out("bp_first", 1, pat(40'hB0_0000_0000, 1));
    for (int c = 0; c < 5; c++) begin
      step();
      expect_out("bp_hold", 1, pat(40'hB0_0000_0000, 1));
      check("bp_adv", 64'(adv_o), 64'd0);
      check("bp_busy", 64'(busy_o), 64'd1);
    end
    rnd_ready_i = 1'b1;
    step();
    expect_out("bp_release", 2, pat(40'hB0_0000_0000, 2));
    check("bp_adv_back", 64'(adv_o), 64'd1);
    step();
    check("bp_idle", 64'(out_vld_o), 64'd0);

    // Fairness: move pointer to 2 via id 1, then ids 0 and 3
    load_pattern(40'hC0_0000_0000);
    pulse(4'b0010);
    step();
    expect_out("fair_setup", 1, pat(40'hC0_0000_0000, 1));
    step();
    pulse(4'b1001);
    step();
    expect_out("fair_first", 3, pat(40'hC0_0000_0000, 3));
    step();
    expect_out("fair_second", 0, pat(40'hC0_0000_0000, 0));
    step();
    check("fair_idle", 64'(out_vld_o), 64'd0);

    // Flush with three slots valid (pointer is 1 beforehand)
    load_pattern(40'hD0_0000_0000);
    pulse(4'b0111);
    check("flush_pre_busy", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_busy", 64'(busy_o), 64'd0);
    check("flush_vld", 64'(out_vld_o), 64'd0);
    check("flush_adv", 64'(adv_o), 64'd1);
    pulse(4'b0011);
    step();
    expect_out("flush_ptr_first", 0, pat(40'hD0_0000_0000, 0));
    step();
    expect_out("flush_ptr_second", 1, pat(40'hD0_0000_0000, 1));
    step();
    check("flush_idle", 64'(out_vld_o), 64'd0);

    // Reset mid-drain (pointer 2 beforehand, 3 after the grant)
    load_pattern(40'hE0_0000_0000);
    pulse(4'b1100);
    step();
    expect_out("rstmid_grant", 2, pat(40'hE0_0000_0000, 2));
    rst = 1'b1;
    #1;
    check("rstmid_adv_high", 64'(adv_o), 64'd0);
    step();
    check("rstmid_vld", 64'(out_vld_o), 64'd0);
    check("rstmid_id", 64'(out_id_o), 64'd0);
    check("rstmid_data", 64'(out_data_o), 64'd0);
    check("rstmid_busy", 64'(busy_o), 64'd0);
    check("rstmid_adv", 64'(adv_o), 64'd0);
    rst = 1'b0;
    #1;
    check("rstmid_adv_after", 64'(adv_o), 64'd1);
    pulse(4'b1001);
    step();
    expect_out("rstmid_ptr_first", 0, pat(40'hE0_0000_0000, 0));
    step();
    expect_out("rstmid_ptr_second", 3, pat(40'hE0_0000_0000, 3));
    step();
    check("rstmid_idle_vld", 64'(out_vld_o), 64'd0);
    check("rstmid_idle_busy", 64'(busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
